// File: rtl/afu_pkg.sv
// rtl/afu_pkg.sv - shared widths, requester IDs and arbiter states for the AFU memory path
// Contents: ADDR_W/DATA_W constants, req_id_t (requester index), arb_state_t (mem_arbiter FSM)
package afu_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 512;

  // Index into the arbiter request vector {wr_req, rd_req[2:0]}
  typedef enum logic [1:0] {
    REQ_IPGU = 2'd0,
    REQ_RDN  = 2'd1,
    REQ_DNN  = 2'd2,
    REQ_RES  = 2'd3
  } req_id_t;

  typedef enum logic [1:0] {
    WAIT_BUF = 2'd0,
    IDLE     = 2'd1,
    RD_WAIT  = 2'd2,
    WR_WAIT  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - combinational 4-way round-robin picker
// Ports: req   - request vector, one bit per requester
//        ptr   - index of the last winner; search starts at ptr+1 and wraps
//        gnt   - one-hot winner (all zero when req is zero)
//        idx   - binary winner index (equals ptr when req is zero)
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk from the farthest offset (ptr itself) down to ptr+1 so the
  // nearest set request after the pointer is the last assignment to win.
  always_comb begin
    gnt  = 4'b0000;
    idx  = ptr;
    cand = ptr;
    for (int off = 4; off >= 1; off--) begin
      cand = ptr + 2'(off);
      if (req[cand]) begin
        gnt = 4'b0001 << cand;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialising round-robin arbiter for the single CCI-P memory port
// Ports: clk, rst (async, active-high)
//        rd_req/rd_addr/rd_gnt/rd_data_vld/rd_data - three read requesters (IPGU, RDN, DNN)
//        wr_req/wr_addr/wr_data/wr_gnt/wr_done     - DNN result write-back
//        mem_*                                      - memory block request/response interface
//        busy, timeout_err                          - status
module mem_arbiter #(
  parameter int ADDR_W      = afu_pkg::ADDR_W,
  parameter int DATA_W      = afu_pkg::DATA_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            rd_req,
  input  logic [3*ADDR_W-1:0]   rd_addr,
  output logic [2:0]            rd_gnt,
  output logic [2:0]            rd_data_vld,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_gnt,
  output logic                  wr_done,
  output logic                  mem_read_request_valid,
  output logic                  mem_write_request_valid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_data_d,
  input  logic                  mem_buffer_addr_valid,
  input  logic                  mem_data_valid,
  input  logic                  mem_write_done,
  input  logic [DATA_W-1:0]     mem_data_q,
  output logic                  busy,
  output logic                  timeout_err
);
  import afu_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_t        state;
  logic [1:0]        ptr;
  logic [1:0]        owner;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              tmo_hit;
  logic [3:0]        req_vec;
  logic [3:0]        arb_gnt;
  logic [1:0]        arb_idx;
  logic              grant_fire;
  logic [ADDR_W-1:0] sel_rd_addr;

  assign req_vec = {wr_req, rd_req};

  rr_arbiter4 u_rr (
    .req (req_vec),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Grants are decided combinationally in IDLE so the requester sees its
  // pulse in the same cycle its address/data are captured.
  assign grant_fire = (state == IDLE) && (|req_vec);
  assign rd_gnt     = grant_fire ? arb_gnt[2:0] : 3'b000;
  assign wr_gnt     = grant_fire & arb_gnt[3];
  assign busy       = grant_fire || (state == RD_WAIT) || (state == WR_WAIT);
  assign tmo_hit    = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    sel_rd_addr = rd_addr[ADDR_W-1:0];
    case (arb_idx)
      2'd1:    sel_rd_addr = rd_addr[2*ADDR_W-1:ADDR_W];
      2'd2:    sel_rd_addr = rd_addr[3*ADDR_W-1:2*ADDR_W];
      default: sel_rd_addr = rd_addr[ADDR_W-1:0];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= WAIT_BUF;
      ptr                     <= 2'd3;
      owner                   <= 2'd0;
      tmo_cnt                 <= '0;
      rd_data_vld             <= 3'b000;
      rd_data                 <= '0;
      wr_done                 <= 1'b0;
      mem_read_request_valid  <= 1'b0;
      mem_write_request_valid <= 1'b0;
      mem_address             <= '0;
      mem_data_d              <= '0;
      timeout_err             <= 1'b0;
    end else begin
      // Strobes and completion pulses are single-cycle by default
      mem_read_request_valid  <= 1'b0;
      mem_write_request_valid <= 1'b0;
      rd_data_vld             <= 3'b000;
      wr_done                 <= 1'b0;

      case (state)
        WAIT_BUF: begin
          // Buffer address only needs to be seen once; never re-checked
          if (mem_buffer_addr_valid) state <= IDLE;
        end

        IDLE: begin
          if (grant_fire) begin
            ptr     <= arb_idx;
            owner   <= arb_idx;
            tmo_cnt <= '0;
            if (arb_idx == REQ_RES) begin
              mem_address             <= wr_addr;
              mem_data_d              <= wr_data;
              mem_write_request_valid <= 1'b1;
              state                   <= WR_WAIT;
            end else begin
              mem_address            <= sel_rd_addr;
              mem_read_request_valid <= 1'b1;
              state                  <= RD_WAIT;
            end
          end
        end

        RD_WAIT: begin
          if (mem_data_valid) begin
            rd_data     <= mem_data_q;
            rd_data_vld <= 3'b001 << owner;
            state       <= IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        WR_WAIT: begin
          if (mem_write_done) begin
            wr_done <= 1'b1;
            state   <= IDLE;
          end else if (tmo_hit) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= WAIT_BUF;
      endcase
    end
  end

endmodule
